mig_tt_sweep: RTL and testbench
===============================

Name: mig_tt_sweep

Overview:
- Exhaustive truth-table sweeper that sits directly upstream and downstream of a synthesized 4-input single-output logic network.
- Drives every input minterm onto x0..x3 and samples the network's y0 after a settle delay.
- Assembles the 16-bit truth table and compares it against an expected table supplied with the start request.
- Result leaves on a valid/ready handshake to the equivalence-checking harness.

Parameters:
- SETTLE_CYCLES, 1, clock cycles between updating x and sampling y; legal range 1..15.
- TT_W, 16, truth-table width (2^4); fixed, not to be overridden.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start_valid  input  1  request to sweep.
- start_ready  output  1  high only in IDLE.
- exp_tt  input  16  expected truth table; bit i = expected y for minterm i; captured on start handshake.
- x  output  4  minterm driven to network; x[0]=x0 ... x[3]=x3; registered.
- y  input  1  network output y0.
- tt_valid  output  1  result available.
- tt_ready  input  1  consumer accepts result.
- tt  output  16  captured truth table; bit i = y sampled while x==i.
- match  output  1  tt == captured exp_tt; valid with tt_valid.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst_n low): state=IDLE, x=0, tt=0, match=0, tt_valid=0, busy=0, start_ready=1, idx=0, cnt=0, exp register=0.
- States: IDLE, SWEEP, DONE.
- IDLE:
  - start_ready=1.
  - On start_valid at an edge: latch exp_tt, set x=0, idx=0, cnt=0, clear tt, go SWEEP.
- SWEEP:
  - Each edge: if cnt==SETTLE_CYCLES-1, write tt[idx]=y and cnt=0; otherwise cnt++.
  - On a sample edge with idx<15: idx++, x=idx+1.
  - On a sample edge with idx==15: compute match from the final tt (including this sample), go DONE; x stays at 15.
- DONE:
  - tt_valid=1; tt and match held stable.
  - On an edge with tt_ready=1: tt_valid=0, x=0, go IDLE.
  - tt and match keep their last values until the next start.
- Latency: start accepted at edge E0; tt_valid rises at edge E0+16*SETTLE_CYCLES. With SETTLE_CYCLES=1 that is 16 cycles.
- start_valid outside IDLE is ignored; not queued.
- tt_ready outside DONE is ignored.
- tt_valid must not drop without tt_ready.
- Back-to-back operation: tt_ready at edge En returns to IDLE; the earliest next start is accepted at En+1.
- Reset mid-sweep or mid-DONE: immediate async return to the reset state; no partial result is emitted.
- y is sampled as-is (no synchronizer); the network is combinational on the same clock domain.

Optional Feature:
- Macro: MIG_TT_SWEEP_ERRCNT_EN.
- Defined:
  - Adds output err_cnt, 5 bits = popcount(tt ^ exp).
  - Adds output first_err, 4 bits = lowest mismatching minterm index, 0 if none.
  - Both update at the DONE transition, hold with tt, and reset to 0.
- Undefined: neither port exists; no popcount logic is synthesized; remaining behaviour identical.

Test Plan:
- Network model y=x0&x1, exp_tt=16'h8888, SETTLE_CYCLES=1: start at E0 -> x steps 0..15 one per cycle; tt_valid at E0+16; tt=16'h8888, match=1.
- Network model y=MAJ(x0,x1,x2), exp_tt=16'hE8E8, SETTLE_CYCLES=3: x holds each value 3 cycles; tt_valid at E0+48; tt=16'hE8E8, match=1.
- Same MAJ model, exp_tt=16'hE8E9: tt=16'hE8E8, match=0; with MIG_TT_SWEEP_ERRCNT_EN, err_cnt=1 and first_err=0.
- Hold tt_ready=0 for 10 cycles in DONE: tt_valid, tt, match stable; start_valid=1 throughout causes no restart; after tt_ready, start accepted on the following edge.
- Pulse rst_n low while idx=7: x=0, tt_valid=0, busy=0 immediately; a new start sweeps from x=0 with correct result.
- Network model y=1, exp_tt=16'hFFFF, start_valid asserted during SWEEP: ignored; single result tt=16'hFFFF, match=1.

Source files
------------

// File: rtl/mig_tt_sweep.sv
// Exhaustive 4-input truth-table sweeper: drives every minterm onto x, samples y after a settle delay,
// and reports the 16-bit table plus a match flag. Optional MIG_TT_SWEEP_ERRCNT_EN adds err_cnt/first_err.
module mig_tt_sweep #(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter int unsigned TT_W          = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_valid,
    output logic            start_ready,
    input  logic [TT_W-1:0] exp_tt,
    output logic [3:0]      x,
    input  logic            y,
    output logic            tt_valid,
    input  logic            tt_ready,
    output logic [TT_W-1:0] tt,
    output logic            match,
`ifdef MIG_TT_SWEEP_ERRCNT_EN
    output logic [4:0]      err_cnt,
    output logic [3:0]      first_err,
`endif
    output logic            busy
);

    localparam int unsigned IDX_W = 4;
    localparam int unsigned CNT_W = 4;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(TT_W - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] x_q, x_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TT_W-1:0]  tt_q, tt_d;
    logic [TT_W-1:0]  exp_q, exp_d;
    logic             match_q, match_d;
    logic             tt_valid_q, tt_valid_d;
    logic             busy_q, busy_d;
    logic             start_ready_q, start_ready_d;
    logic [TT_W-1:0]  tt_sampled;
    logic             done_tr;

    // Next-state and datapath updates
    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        tt_d       = tt_q;
        exp_d      = exp_q;
        match_d    = match_q;
        done_tr    = 1'b0;
        tt_sampled = tt_q;
        tt_sampled[idx_q] = y;

        case (state_q)
            IDLE: begin
                if (start_valid) begin
                    exp_d   = exp_tt;
                    x_d     = '0;
                    idx_d   = '0;
                    cnt_d   = '0;
                    tt_d    = '0;
                    state_d = SWEEP;
                end
            end
            SWEEP: begin
                if (cnt_q == CNT_LAST) begin
                    tt_d  = tt_sampled;
                    cnt_d = '0;
                    if (idx_q == IDX_LAST) begin
                        match_d = (tt_sampled == exp_q);
                        done_tr = 1'b1;
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                        x_d   = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (tt_ready) begin
                    x_d     = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        tt_valid_d    = (state_d == DONE);
        busy_d        = (state_d != IDLE);
        start_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            x_q           <= '0;
            idx_q         <= '0;
            cnt_q         <= '0;
            tt_q          <= '0;
            exp_q         <= '0;
            match_q       <= 1'b0;
            tt_valid_q    <= 1'b0;
            busy_q        <= 1'b0;
            start_ready_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            x_q           <= x_d;
            idx_q         <= idx_d;
            cnt_q         <= cnt_d;
            tt_q          <= tt_d;
            exp_q         <= exp_d;
            match_q       <= match_d;
            tt_valid_q    <= tt_valid_d;
            busy_q        <= busy_d;
            start_ready_q <= start_ready_d;
        end
    end

`ifdef MIG_TT_SWEEP_ERRCNT_EN
    logic [4:0]      err_cnt_q, err_cnt_d;
    logic [3:0]      first_err_q, first_err_d;
    logic [TT_W-1:0] diff;
    logic            found;

    // Mismatch statistics on the final table, captured only on the DONE transition
    always_comb begin
        err_cnt_d   = err_cnt_q;
        first_err_d = first_err_q;
        diff        = tt_sampled ^ exp_q;
        found       = 1'b0;
        if (done_tr) begin
            err_cnt_d   = '0;
            first_err_d = '0;
            for (int unsigned i = 0; i < TT_W; i++) begin
                err_cnt_d = err_cnt_d + 5'(diff[i]);
                if (diff[i] && !found) begin
                    first_err_d = 4'(i);
                    found       = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q   <= '0;
            first_err_q <= '0;
        end else begin
            err_cnt_q   <= err_cnt_d;
            first_err_q <= first_err_d;
        end
    end

    assign err_cnt   = err_cnt_q;
    assign first_err = first_err_q;
`endif

    assign start_ready = start_ready_q;
    assign x           = x_q;
    assign tt_valid    = tt_valid_q;
    assign tt          = tt_q;
    assign match       = match_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_mig_tt_sweep.sv
// Bench for mig_tt_sweep: two instances (settle 1 and 3) sweep the same behavioural network,
// checked against a table computed directly from the network function.
module tb_mig_tt_sweep;

    logic        clk;
    logic        rst_n;
    logic        start_valid;
    logic        tt_ready;
    logic [15:0] exp_tt;
    logic [3:0]  x1, x3;
    logic        y1, y3;
    logic        sr1, sr3, v1, v3, m1, m3, b1, b3;
    logic [15:0] tt1, tt3;
`ifdef MIG_TT_SWEEP_ERRCNT_EN
    logic [4:0]  ec1, ec3;
    logic [3:0]  fe1, fe3;
`endif

    int          fsel;
    logic [15:0] rtt;
    int          n_assert = 0;
    int          n_fail   = 0;

    // Network under sweep: 0 = x0&x1, 1 = MAJ(x0,x1,x2), 2 = constant 1, else arbitrary table
    function automatic logic net(input int f, input logic [3:0] xv, input logic [15:0] r);
        case (f)
            0:       return xv[0] & xv[1];
            1:       return (xv[0] & xv[1]) | (xv[0] & xv[2]) | (xv[1] & xv[2]);
            2:       return 1'b1;
            default: return r[xv];
        endcase
    endfunction

    assign y1 = net(fsel, x1, rtt);
    assign y3 = net(fsel, x3, rtt);

    mig_tt_sweep #(.SETTLE_CYCLES(1)) u_s1 (
        .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(sr1),
        .exp_tt(exp_tt), .x(x1), .y(y1), .tt_valid(v1), .tt_ready(tt_ready),
        .tt(tt1), .match(m1),
`ifdef MIG_TT_SWEEP_ERRCNT_EN
        .err_cnt(ec1), .first_err(fe1),
`endif
        .busy(b1)
    );

    mig_tt_sweep #(.SETTLE_CYCLES(3)) u_s3 (
        .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(sr3),
        .exp_tt(exp_tt), .x(x3), .y(y3), .tt_valid(v3), .tt_ready(tt_ready),
        .tt(tt3), .match(m3),
`ifdef MIG_TT_SWEEP_ERRCNT_EN
        .err_cnt(ec3), .first_err(fe3),
`endif
        .busy(b3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_x1"}, 32'(x1), 32'd0);
        chk({tag, "_x3"}, 32'(x3), 32'd0);
        chk({tag, "_v1"}, 32'(v1), 32'd0);
        chk({tag, "_v3"}, 32'(v3), 32'd0);
        chk({tag, "_b1"}, 32'(b1), 32'd0);
        chk({tag, "_b3"}, 32'(b3), 32'd0);
        chk({tag, "_sr1"}, 32'(sr1), 32'd1);
        chk({tag, "_sr3"}, 32'(sr3), 32'd1);
    endtask

    // One full transaction on both instances; hold = DONE cycles with tt_ready low and start high,
    // poke = assert start mid-sweep, keep = leave start high after release (back-to-back)
    task automatic run_sweep(input int f, input logic [15:0] r, input logic [15:0] e,
                             input int hold, input bit poke, input bit keep);
        logic [15:0] ref_tt;
        logic        ref_m;
        int          xe1, xe3;
        fsel = f;
        rtt  = r;
        for (int i = 0; i < 16; i++) ref_tt[i] = net(f, 4'(i), r);
        ref_m = (ref_tt == e);

        exp_tt      = e;
        start_valid = 1'b1;
        @(posedge clk); #1;
        exp_tt      = 16'($urandom);
        start_valid = 1'b0;
        chk("start_x1", 32'(x1), 32'd0);
        chk("start_x3", 32'(x3), 32'd0);
        chk("start_b1", 32'(b1), 32'd1);
        chk("start_sr3", 32'(sr3), 32'd0);

        for (int c = 1; c <= 48; c++) begin
            start_valid = poke && (c >= 5) && (c <= 8);
            @(posedge clk); #1;
            xe1 = (c < 15) ? c : 15;
            xe3 = (c / 3 < 15) ? c / 3 : 15;
            chk("sweep_x1", 32'(x1), 32'(xe1));
            chk("sweep_x3", 32'(x3), 32'(xe3));
            chk("sweep_v1", 32'(v1), 32'(c >= 16));
            chk("sweep_v3", 32'(v3), 32'(c >= 48));
            chk("sweep_b3", 32'(b3), 32'd1);
        end
        start_valid = 1'b0;

        chk("res_tt1", 32'(tt1), 32'(ref_tt));
        chk("res_tt3", 32'(tt3), 32'(ref_tt));
        chk("res_m1", 32'(m1), 32'(ref_m));
        chk("res_m3", 32'(m3), 32'(ref_m));
`ifdef MIG_TT_SWEEP_ERRCNT_EN
        begin
            int pc;
            int fe;
            pc = 0;
            fe = -1;
            for (int i = 0; i < 16; i++) begin
                if (ref_tt[i] != e[i]) begin
                    pc++;
                    if (fe < 0) fe = i;
                end
            end
            if (fe < 0) fe = 0;
            chk("res_ec1", 32'(ec1), 32'(pc));
            chk("res_ec3", 32'(ec3), 32'(pc));
            chk("res_fe1", 32'(fe1), 32'(fe));
            chk("res_fe3", 32'(fe3), 32'(fe));
        end
`endif

        for (int h = 0; h < hold; h++) begin
            start_valid = 1'b1;
            @(posedge clk); #1;
            chk("hold_v1", 32'(v1), 32'd1);
            chk("hold_v3", 32'(v3), 32'd1);
            chk("hold_tt1", 32'(tt1), 32'(ref_tt));
            chk("hold_m3", 32'(m3), 32'(ref_m));
            chk("hold_x3", 32'(x3), 32'd15);
        end

        tt_ready    = 1'b1;
        start_valid = keep;
        @(posedge clk); #1;
        tt_ready = 1'b0;
        chk_idle("rel");
        chk("rel_tt1", 32'(tt1), 32'(ref_tt));
        chk("rel_m1", 32'(m1), 32'(ref_m));
    endtask

    initial begin
        logic [15:0] r;
        logic [15:0] e;
        rst_n       = 1'b0;
        start_valid = 1'b0;
        tt_ready    = 1'b0;
        exp_tt      = 16'h0;
        fsel        = 0;
        rtt         = 16'h0;

        #12;
        chk_idle("rst");
        chk("rst_tt1", 32'(tt1), 32'd0);
        chk("rst_m3", 32'(m3), 32'd0);
        #11 rst_n = 1'b1;
        @(posedge clk); #1;

        run_sweep(0, 16'h0, 16'h8888, 0, 1'b0, 1'b0);
        run_sweep(1, 16'h0, 16'hE8E8, 0, 1'b0, 1'b0);
        run_sweep(1, 16'h0, 16'hE8E9, 10, 1'b0, 1'b1);
        run_sweep(2, 16'h0, 16'hFFFF, 0, 1'b1, 1'b0);

        // Asynchronous reset in the middle of a sweep
        fsel        = 1;
        exp_tt      = 16'hE8E8;
        start_valid = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        chk("mid_x1", 32'(x1), 32'd7);
        #2 rst_n = 1'b0;
        #1;
        chk_idle("arst");
        chk("arst_tt1", 32'(tt1), 32'd0);
        chk("arst_m1", 32'(m1), 32'd0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        chk_idle("arst_post");
        run_sweep(1, 16'h0, 16'hE8E8, 0, 1'b0, 1'b0);

        for (int k = 0; k < 6; k++) begin
            r = 16'($urandom);
            case (k % 3)
                0:       e = r;
                1:       e = r ^ (16'h1 << $urandom_range(15, 0));
                default: e = 16'($urandom);
            endcase
            run_sweep(3, r, e, int'($urandom_range(3, 0)), bit'(k % 2), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
